// File: rtl/cva6_axi_txn_limiter_if.sv
// AXI_BUS: AXI4+ATOP bus bundle with master/slave views
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;
  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/cva6_axi_txn_limiter.sv
// cva6_axi_txn_limiter: caps outstanding AXI bursts, orders W behind AW, records response errors
module cva6_axi_txn_limiter #(
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned MAX_RD_TXNS    = 4,
  parameter int unsigned MAX_WR_TXNS    = 4,
  parameter int unsigned CNT_WIDTH      = $clog2((MAX_RD_TXNS > MAX_WR_TXNS ? MAX_RD_TXNS : MAX_WR_TXNS) + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  AXI_BUS.Slave                   slv,
  AXI_BUS.Master                  mst,
  output logic [CNT_WIDTH-1:0]    rd_outstanding_o,
  output logic [CNT_WIDTH-1:0]    wr_outstanding_o,
  output logic [15:0]             err_cnt_o,
  output logic                    err_valid_o,
  output logic [AXI_ID_WIDTH-1:0] err_id_o,
  output logic                    err_is_write_o,
  input  logic                    err_clear_i
);
  logic [CNT_WIDTH-1:0] rd_cnt, wr_cnt, w_credit;
  logic rd_ok, wr_ok, w_ok, ar_hs, aw_hs, wl_hs, rl_hs, b_hs, r_err, b_err;
  logic [16:0] err_sum;
  assign mst.aw_id     = slv.aw_id;
  assign mst.aw_addr   = slv.aw_addr;
  assign mst.aw_len    = slv.aw_len;
  assign mst.aw_size   = slv.aw_size;
  assign mst.aw_burst  = slv.aw_burst;
  assign mst.aw_lock   = slv.aw_lock;
  assign mst.aw_cache  = slv.aw_cache;
  assign mst.aw_prot   = slv.aw_prot;
  assign mst.aw_qos    = slv.aw_qos;
  assign mst.aw_region = slv.aw_region;
  assign mst.aw_atop   = slv.aw_atop;
  assign mst.aw_user   = slv.aw_user;
  assign mst.w_data    = slv.w_data;
  assign mst.w_strb    = slv.w_strb;
  assign mst.w_last    = slv.w_last;
  assign mst.w_user    = slv.w_user;
  assign slv.b_id      = mst.b_id;
  assign slv.b_resp    = mst.b_resp;
  assign slv.b_user    = mst.b_user;
  assign slv.b_valid   = mst.b_valid;
  assign mst.b_ready   = slv.b_ready;
  assign mst.ar_id     = slv.ar_id;
  assign mst.ar_addr   = slv.ar_addr;
  assign mst.ar_len    = slv.ar_len;
  assign mst.ar_size   = slv.ar_size;
  assign mst.ar_burst  = slv.ar_burst;
  assign mst.ar_lock   = slv.ar_lock;
  assign mst.ar_cache  = slv.ar_cache;
  assign mst.ar_prot   = slv.ar_prot;
  assign mst.ar_qos    = slv.ar_qos;
  assign mst.ar_region = slv.ar_region;
  assign mst.ar_user   = slv.ar_user;
  assign slv.r_id      = mst.r_id;
  assign slv.r_data    = mst.r_data;
  assign slv.r_resp    = mst.r_resp;
  assign slv.r_last    = mst.r_last;
  assign slv.r_user    = mst.r_user;
  assign slv.r_valid   = mst.r_valid;
  assign mst.r_ready   = slv.r_ready;
  // gates look only at registered counts, so no cross-channel combinational paths
  assign rd_ok = ~rst_i & (rd_cnt < CNT_WIDTH'(MAX_RD_TXNS));
  assign wr_ok = ~rst_i & (wr_cnt < CNT_WIDTH'(MAX_WR_TXNS));
  assign w_ok  = ~rst_i & (w_credit != '0);
  assign mst.ar_valid = slv.ar_valid & rd_ok;
  assign slv.ar_ready = mst.ar_ready & rd_ok;
  assign mst.aw_valid = slv.aw_valid & wr_ok;
  assign slv.aw_ready = mst.aw_ready & wr_ok;
  assign mst.w_valid  = slv.w_valid & w_ok;
  assign slv.w_ready  = mst.w_ready & w_ok;
  assign ar_hs = mst.ar_valid & mst.ar_ready;
  assign aw_hs = mst.aw_valid & mst.aw_ready;
  assign wl_hs = mst.w_valid & mst.w_ready & slv.w_last;
  assign rl_hs = mst.r_valid & slv.r_ready & mst.r_last;
  assign b_hs  = mst.b_valid & slv.b_ready;
  assign r_err = mst.r_valid & slv.r_ready & mst.r_resp[1];
  assign b_err = b_hs & mst.b_resp[1];
  assign err_sum = {1'b0, err_clear_i ? 16'h0 : err_cnt_o} + 17'(r_err) + 17'(b_err);
  assign rd_outstanding_o = rd_cnt;
  assign wr_outstanding_o = wr_cnt;
  function automatic logic [CNT_WIDTH-1:0] upd(input logic [CNT_WIDTH-1:0] c, input logic inc, input logic dec);
    return (inc & ~dec) ? c + CNT_WIDTH'(1) : (dec & ~inc & (c != '0)) ? c - CNT_WIDTH'(1) : c;
  endfunction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt         <= '0;
      wr_cnt         <= '0;
      w_credit       <= '0;
      err_cnt_o      <= '0;
      err_valid_o    <= 1'b0;
      err_id_o       <= '0;
      err_is_write_o <= 1'b0;
    end else begin
      rd_cnt    <= upd(rd_cnt, ar_hs, rl_hs);
      wr_cnt    <= upd(wr_cnt, aw_hs, b_hs);
      w_credit  <= upd(w_credit, aw_hs, wl_hs);
      err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (err_clear_i | ~err_valid_o) begin
        err_valid_o    <= r_err | b_err;
        err_id_o       <= b_err ? mst.b_id : r_err ? mst.r_id : '0;
        err_is_write_o <= b_err;
      end
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(rl_hs && !ar_hs && rd_cnt == '0)) else $error("read response underflow");
      assert (!(b_hs && !aw_hs && wr_cnt == '0)) else $error("write response underflow");
    end
  end
`endif
endmodule

// File: tb/tb_cva6_axi_txn_limiter.sv
// tb_cva6_axi_txn_limiter: directed self-checking bench for the AXI transaction limiter
module tb_cva6_axi_txn_limiter;
  logic clk = 1'b0, rst, err_clear;
  logic [2:0] rd_o, wr_o;
  logic [15:0] ec;
  logic ev, ew;
  logic [4:0] eid;
  int errors = 0, checks = 0;
  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1)) slv_b ();
  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1)) mst_b ();
  cva6_axi_txn_limiter #(.MAX_RD_TXNS(4), .MAX_WR_TXNS(4)) dut (
    .clk_i(clk), .rst_i(rst), .slv(slv_b), .mst(mst_b),
    .rd_outstanding_o(rd_o), .wr_outstanding_o(wr_o), .err_cnt_o(ec),
    .err_valid_o(ev), .err_id_o(eid), .err_is_write_o(ew), .err_clear_i(err_clear)
  );
  always #5 clk = ~clk;
  task automatic nx;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1; err_clear = 1'b0;
    slv_b.aw_id = '0; slv_b.aw_addr = '0; slv_b.aw_len = '0; slv_b.aw_size = '0; slv_b.aw_burst = '0;
    slv_b.aw_lock = '0; slv_b.aw_cache = '0; slv_b.aw_prot = '0; slv_b.aw_qos = '0; slv_b.aw_region = '0;
    slv_b.aw_atop = '0; slv_b.aw_user = '0; slv_b.aw_valid = 0;
    slv_b.w_data = '0; slv_b.w_strb = '0; slv_b.w_last = 0; slv_b.w_user = '0; slv_b.w_valid = 0;
    slv_b.b_ready = 0; slv_b.r_ready = 0;
    slv_b.ar_id = '0; slv_b.ar_addr = '0; slv_b.ar_len = '0; slv_b.ar_size = '0; slv_b.ar_burst = '0;
    slv_b.ar_lock = '0; slv_b.ar_cache = '0; slv_b.ar_prot = '0; slv_b.ar_qos = '0; slv_b.ar_region = '0;
    slv_b.ar_user = '0; slv_b.ar_valid = 0;
    mst_b.aw_ready = 0; mst_b.w_ready = 0; mst_b.ar_ready = 0;
    mst_b.b_id = '0; mst_b.b_resp = '0; mst_b.b_user = '0; mst_b.b_valid = 0;
    mst_b.r_id = '0; mst_b.r_data = '0; mst_b.r_resp = '0; mst_b.r_last = 0; mst_b.r_user = '0; mst_b.r_valid = 0;
    nx; nx;
    rst = 1'b0;
    #1;
    chk("rst_rd", 32'(rd_o), 0); chk("rst_wr", 32'(wr_o), 0); chk("rst_ec", 32'(ec), 0);
    chk("rst_ev", 32'(ev), 0); chk("rst_eid", 32'(eid), 0); chk("rst_ew", 32'(ew), 0);
    slv_b.ar_valid = 1; mst_b.ar_ready = 1; slv_b.r_ready = 1; slv_b.b_ready = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("ar_ready_%0d", k), 32'(slv_b.ar_ready), (k < 4) ? 1 : 0);
      chk($sformatf("rd_cnt_%0d", k), 32'(rd_o), (k < 4) ? k : 4);
      nx;
    end
    mst_b.r_valid = 1; mst_b.r_last = 1;
    #1;
    chk("ar_blocked_full", 32'(mst_b.ar_valid), 0); chk("rd_full", 32'(rd_o), 4);
    nx;
    chk("rd_freed", 32'(rd_o), 3); chk("ar_fifth", 32'(slv_b.ar_ready), 1);
    nx;
    mst_b.r_valid = 0;
    #1;
    chk("rd_same_cycle", 32'(rd_o), 3);
    nx;
    chk("rd_refull", 32'(rd_o), 4); chk("ar_refull", 32'(slv_b.ar_ready), 0);
    slv_b.ar_valid = 0; mst_b.r_valid = 1; mst_b.r_last = 1;
    repeat (4) nx;
    mst_b.r_valid = 0; mst_b.r_last = 0;
    #1;
    chk("rd_drained", 32'(rd_o), 0);
    slv_b.w_valid = 1; slv_b.w_last = 0; mst_b.w_ready = 1; mst_b.aw_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("w_held_%0d", k), 32'(mst_b.w_valid), 0);
      nx;
    end
    slv_b.aw_valid = 1;
    #1;
    chk("w_held_aw_cycle", 32'(mst_b.w_valid), 0); chk("aw_pass", 32'(mst_b.aw_valid), 1);
    nx;
    slv_b.aw_valid = 0;
    #1;
    chk("wr_one", 32'(wr_o), 1); chk("w_fwd0", 32'(mst_b.w_valid), 1);
    nx;
    slv_b.w_last = 1;
    #1;
    chk("w_fwd_last", 32'(mst_b.w_valid), 1);
    nx;
    chk("w_credit_zero", 32'(mst_b.w_valid), 0); chk("w_ready_zero", 32'(slv_b.w_ready), 0);
    slv_b.w_valid = 0; slv_b.w_last = 0;
    mst_b.b_valid = 1; mst_b.b_resp = 2'b10; mst_b.b_id = 5'h03;
    nx;
    mst_b.b_valid = 0;
    #1;
    chk("wr_done", 32'(wr_o), 0); chk("ec_b", 32'(ec), 1); chk("ev_b", 32'(ev), 1);
    chk("eid_b", 32'(eid), 3); chk("ew_b", 32'(ew), 1);
    mst_b.r_valid = 1; mst_b.r_last = 0; mst_b.r_resp = 2'b11; mst_b.r_id = 5'h07;
    nx;
    mst_b.r_valid = 0;
    #1;
    chk("ec_two", 32'(ec), 2); chk("eid_frozen", 32'(eid), 3); chk("ew_frozen", 32'(ew), 1);
    err_clear = 1; slv_b.aw_valid = 1;
    nx;
    err_clear = 0; slv_b.aw_valid = 0; slv_b.w_valid = 1; slv_b.w_last = 1;
    #1;
    chk("ec_cleared", 32'(ec), 0); chk("ev_cleared", 32'(ev), 0); chk("wr_after_clr", 32'(wr_o), 1);
    nx;
    slv_b.w_valid = 0;
    mst_b.r_valid = 1; mst_b.r_resp = 2'b10; mst_b.r_id = 5'h07;
    mst_b.b_valid = 1; mst_b.b_resp = 2'b11; mst_b.b_id = 5'h09;
    nx;
    mst_b.r_valid = 0; mst_b.b_valid = 0;
    #1;
    chk("ec_dual", 32'(ec), 2); chk("eid_dual", 32'(eid), 9); chk("ew_dual", 32'(ew), 1); chk("wr_dual", 32'(wr_o), 0);
    err_clear = 1; slv_b.aw_valid = 1;
    nx;
    err_clear = 0;
    slv_b.w_valid = 1; slv_b.w_last = 1;
    mst_b.b_valid = 1; mst_b.b_resp = 2'b10; mst_b.b_id = 5'h11;
    #1;
    chk("sat_start", 32'(ec), 0); chk("sat_wr", 32'(wr_o), 1);
    repeat (65534) nx;
    chk("sat_fffe", 32'(ec), 32'hFFFE); chk("sat_eid", 32'(eid), 32'h11);
    nx; nx; nx;
    chk("sat_ffff", 32'(ec), 32'hFFFF); chk("sat_wr_steady", 32'(wr_o), 1);
    err_clear = 1; mst_b.b_id = 5'h04;
    nx;
    err_clear = 0;
    #1;
    chk("clr_new_ec", 32'(ec), 1); chk("clr_new_eid", 32'(eid), 4); chk("clr_new_ev", 32'(ev), 1);
    mst_b.b_valid = 0; slv_b.w_valid = 0; slv_b.w_last = 0;
    nx;
    slv_b.aw_valid = 0; slv_b.ar_valid = 1;
    repeat (3) nx;
    chk("pre_rst_rd", 32'(rd_o), 3); chk("pre_rst_wr", 32'(wr_o), 2);
    rst = 1; slv_b.aw_valid = 1; slv_b.w_valid = 1; mst_b.r_valid = 1;
    #1;
    chk("rst_ar_valid", 32'(mst_b.ar_valid), 0); chk("rst_ar_ready", 32'(slv_b.ar_ready), 0);
    chk("rst_aw_valid", 32'(mst_b.aw_valid), 0); chk("rst_aw_ready", 32'(slv_b.aw_ready), 0);
    chk("rst_w_valid", 32'(mst_b.w_valid), 0); chk("rst_w_ready", 32'(slv_b.w_ready), 0);
    chk("rst_r_pass", 32'(slv_b.r_valid), 1);
    nx;
    chk("rst2_rd", 32'(rd_o), 0); chk("rst2_wr", 32'(wr_o), 0); chk("rst2_ec", 32'(ec), 0);
    chk("rst2_ev", 32'(ev), 0); chk("rst2_eid", 32'(eid), 0); chk("rst2_ew", 32'(ew), 0);
    rst = 0; slv_b.ar_valid = 0; slv_b.aw_valid = 0; slv_b.w_valid = 0; mst_b.r_valid = 0;
    nx;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
